// File: rtl/sequential_divider_pkg.sv
// Shared definitions for the sequential divider.
//   ST_IDLE / ST_RUN / ST_DONE : 2-bit FSM state encodings
package sequential_divider_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter for the sequential divider.
// Counts completed shift-subtract iterations; terminal count is SIZE.
// Ports:
//   Clock     in   clock, all updates on posedge
//   iReset_n  in   synchronous reset, active-low
//   iClear    in   return count to 0 (operand accept)
//   iEnable   in   advance by one (one iteration performed this cycle)
//   oLastIter out  this enabled cycle brings the count to SIZE
module div_iter_counter #(
    parameter int SIZE  = 32,
    parameter int CNT_W = $clog2(SIZE + 1)
) (
    input  logic Clock,
    input  logic iReset_n,
    input  logic iClear,
    input  logic iEnable,
    output logic oLastIter
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge Clock) begin
        if (!iReset_n) begin
            count <= '0;
        end else if (iClear) begin
            count <= '0;
        end else if (iEnable) begin
            count <= count + CNT_W'(1);
        end
    end

    // Flag the increment that reaches SIZE so the FSM can leave RUN on the
    // same edge that performs the final iteration.
    assign oLastIter = iEnable && (count == CNT_W'(SIZE - 1));

endmodule

// File: rtl/sequential_divider.sv
// Unsigned restoring shift-subtract divider, one quotient bit per clock.
// Ports:
//   Clock       in   clock, all updates on posedge
//   iReset_n    in   synchronous reset, active-low
//   iStart      in   request, accepted in IDLE or DONE
//   iDividend   in   dividend, captured on accept
//   iDivisor    in   divisor, captured on accept
//   oQuotient   out  quotient, updated on entry to DONE, held until next DONE
//   oRemainder  out  remainder, same validity as oQuotient
//   oBusy       out  high in RUN
//   oDone       out  one-cycle pulse in DONE
//   oDivByZero  out  divisor was zero, same validity as oQuotient
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for iStart; previous results held
// RUN     | one restoring iteration per cycle, SIZE cycles
// DONE    | results valid, oDone pulse; iStart here is accepted
module sequential_divider
    import sequential_divider_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            Clock,
    input  logic            iReset_n,
    input  logic            iStart,
    input  logic [SIZE-1:0] iDividend,
    input  logic [SIZE-1:0] iDivisor,
    output logic [SIZE-1:0] oQuotient,
    output logic [SIZE-1:0] oRemainder,
    output logic            oBusy,
    output logic            oDone,
    output logic            oDivByZero
);

    localparam int CNT_W = $clog2(SIZE + 1);

    logic [1:0]      state;
    logic [SIZE-1:0] divisor_q;
    logic [SIZE-1:0] work_q;
    logic [SIZE-1:0] work_r;
    logic [SIZE-1:0] quotient_q;
    logic [SIZE-1:0] remainder_q;
    logic            div_by_zero_q;

    logic            accept;
    logic            last_iter;
    logic [SIZE:0]   rt;
    logic            ge;
    logic [SIZE-1:0] q_next;
    logic [SIZE-1:0] r_next;

    assign accept = iStart && ((state == ST_IDLE) || (state == ST_DONE));

    div_iter_counter #(
        .SIZE  (SIZE),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .Clock     (Clock),
        .iReset_n  (iReset_n),
        .iClear    (accept),
        .iEnable   (state == ST_RUN),
        .oLastIter (last_iter)
    );

    // The partial remainder is stored SIZE bits wide: after a restoring step
    // it is always below the divisor, so its (SIZE+1)th bit is always 0. The
    // shifted value rt still needs SIZE+1 bits; when its top bit is set it
    // is certainly >= divisor and the SIZE-bit subtraction wraps to the
    // correct (small) result.
    always_comb begin
        rt     = {work_r, work_q[SIZE-1]};
        ge     = rt[SIZE] || (rt[SIZE-1:0] >= divisor_q);
        q_next = {work_q[SIZE-2:0], ge};
        r_next = ge ? (rt[SIZE-1:0] - divisor_q) : rt[SIZE-1:0];
    end

    always_ff @(posedge Clock) begin
        if (!iReset_n) begin
            state         <= ST_IDLE;
            divisor_q     <= '0;
            work_q        <= '0;
            work_r        <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        divisor_q <= iDivisor;
                        work_q    <= iDividend;
                        work_r    <= '0;
                        if (iDivisor == '0) begin
                            // No iterations needed; publish the fixed result.
                            state         <= ST_DONE;
                            quotient_q    <= '1;
                            remainder_q   <= iDividend;
                            div_by_zero_q <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    work_q <= q_next;
                    work_r <= r_next;
                    if (last_iter) begin
                        state         <= ST_DONE;
                        quotient_q    <= q_next;
                        remainder_q   <= r_next;
                        div_by_zero_q <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oQuotient  = quotient_q;
    assign oRemainder = remainder_q;
    assign oDivByZero = div_by_zero_q;
    assign oBusy      = (state == ST_RUN);
    assign oDone      = (state == ST_DONE);

endmodule
